// File: rtl/path_access_sched.sv
// ORAM path-access sequencer: arbitrates frontend/eviction requests and walks the
// address generator through read, write-back hold and write passes. Define
// PATH_HDR_PREREAD_EN to prepend a header-only read pass to every access.
module path_access_sched #(
  parameter int ORAML    = 31,
  parameter int CntWidth = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                FEValid,
  input  logic [ORAML-1:0]    FELeaf,
  output logic                FEReady,
  input  logic                EVValid,
  input  logic [ORAML-1:0]    EVLeaf,
  output logic                EVReady,
  output logic                AGStart,
  output logic                AGRW,
  output logic                AGBH,
  output logic [ORAML-1:0]    AGLeaf,
  input  logic                AGReady,
  input  logic                WBGo,
  output logic                Busy,
  output logic                CurSrc,
  output logic                Done,
  output logic [CntWidth-1:0] AccessCount
);

  typedef enum logic [3:0] {
    IDLE,
`ifdef PATH_HDR_PREREAD_EN
    HDR_ISSUE,
    HDR_WAIT,
`endif
    RD_ISSUE,
    RD_WAIT,
    WB_HOLD,
    WR_ISSUE,
    WR_WAIT,
    DONE
  } state_t;

`ifdef PATH_HDR_PREREAD_EN
  localparam state_t FirstPass = HDR_ISSUE;
`else
  localparam state_t FirstPass = RD_ISSUE;
`endif

  state_t state, state_next;
  logic   last_grant;
  logic   seen_busy;
  logic   grant_fe, grant_ev;
  logic   in_issue;

  // Round robin: on a tie, the source that did not win last time goes first.
  assign grant_fe = FEValid && !(EVValid && !last_grant);
  assign grant_ev = EVValid && !grant_fe;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    FEReady    = 1'b0;
    EVReady    = 1'b0;
    AGStart    = 1'b0;
    in_issue   = 1'b0;
    case (state)
      IDLE: begin
        FEReady = grant_fe && !Reset;
        EVReady = grant_ev && !Reset;
        if (grant_fe || grant_ev) state_next = FirstPass;
      end
`ifdef PATH_HDR_PREREAD_EN
      HDR_ISSUE: begin
        in_issue = 1'b1;
        AGStart  = AGReady;
        if (AGReady) state_next = HDR_WAIT;
      end
      HDR_WAIT: if (seen_busy && AGReady) state_next = RD_ISSUE;
`endif
      RD_ISSUE: begin
        in_issue = 1'b1;
        AGStart  = AGReady;
        if (AGReady) state_next = RD_WAIT;
      end
      RD_WAIT:  if (seen_busy && AGReady) state_next = WB_HOLD;
      WB_HOLD:  if (WBGo) state_next = WR_ISSUE;
      WR_ISSUE: begin
        in_issue = 1'b1;
        AGStart  = AGReady;
        if (AGReady) state_next = WR_WAIT;
      end
      WR_WAIT:  if (seen_busy && AGReady) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign AGRW = !(state == WR_ISSUE || state == WR_WAIT);
`ifdef PATH_HDR_PREREAD_EN
  assign AGBH = (state == HDR_ISSUE || state == HDR_WAIT);
`else
  assign AGBH = 1'b0;
`endif
  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      AGLeaf      <= '0;
      CurSrc      <= 1'b0;
      seen_busy   <= 1'b0;
      AccessCount <= '0;
    end else begin
      state <= state_next;
      if (FEValid && FEReady) begin
        AGLeaf     <= FELeaf;
        CurSrc     <= 1'b0;
        last_grant <= 1'b0;
      end else if (EVValid && EVReady) begin
        AGLeaf     <= EVLeaf;
        CurSrc     <= 1'b1;
        last_grant <= 1'b1;
      end
      // Cleared as the pass is launched, so the wait state only exits after the
      // generator has visibly gone busy and come back.
      if (in_issue && AGReady) seen_busy <= 1'b0;
      else if (!AGReady)       seen_busy <= 1'b1;
      if (state == DONE) AccessCount <= AccessCount + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_path_access_sched.sv
// Directed bench for path_access_sched with a simple address-generator model
// that stays busy for a fixed number of cycles after each start pulse.
module tb_path_access_sched;

  localparam int L  = 4;
  localparam int CW = 2;
`ifdef PATH_HDR_PREREAD_EN
  localparam int NP = 3;
`else
  localparam int NP = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fe_valid, ev_valid, fe_ready, ev_ready;
  logic [L-1:0]  fe_leaf, ev_leaf, ag_leaf;
  logic          ag_start, ag_rw, ag_bh, ag_ready, wb_go;
  logic          busy, cur_src, done;
  logic [CW-1:0] access_count;

  always #5 clk = ~clk;

  path_access_sched #(.ORAML(L), .CntWidth(CW)) dut (
    .Clock(clk), .Reset(rst),
    .FEValid(fe_valid), .FELeaf(fe_leaf), .FEReady(fe_ready),
    .EVValid(ev_valid), .EVLeaf(ev_leaf), .EVReady(ev_ready),
    .AGStart(ag_start), .AGRW(ag_rw), .AGBH(ag_bh), .AGLeaf(ag_leaf),
    .AGReady(ag_ready), .WBGo(wb_go),
    .Busy(busy), .CurSrc(cur_src), .Done(done), .AccessCount(access_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected pass sequence: optional header read, full read, full write.
  function automatic logic exp_rw(input int i);
    return (i < NP - 1);
  endfunction

  function automatic logic exp_bh(input int i);
`ifdef PATH_HDR_PREREAD_EN
    return (i == 0);
`else
    return 1'b0;
`endif
  endfunction

  int           ag_cnt   = 0;
  int           ag_lat   = 5;
  bit           ag_stall = 1'b0;
  logic         st_rw[16];
  logic         st_bh[16];
  logic [L-1:0] st_leaf[16];
  int           n_st, n_done;
  bit           hs_fe, hs_ev;
  int           exp_count = 0;

  // One clock: sample at the falling edge, then update the generator model just after the rising edge.
  task automatic cycle();
    bit pend;
    @(negedge clk);
    hs_fe = fe_valid && fe_ready;
    hs_ev = ev_valid && ev_ready;
    if (done) n_done++;
    pend = ag_start;
    if (ag_start) begin
      if (n_st < 16) begin
        st_rw[n_st]   = ag_rw;
        st_bh[n_st]   = ag_bh;
        st_leaf[n_st] = ag_leaf;
      end
      n_st++;
      check("start_while_ready", ag_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    if (pend) ag_cnt = ag_lat;
    else if (ag_cnt > 0) ag_cnt--;
    ag_ready = (ag_cnt == 0) && !ag_stall;
  endtask

  task automatic wait_grant(input string tag);
    int t = 0;
    hs_fe = 1'b0;
    hs_ev = 1'b0;
    while (!(hs_fe || hs_ev) && t < 20) begin
      cycle();
      t++;
    end
    check({tag, "_grant_seen"}, hs_fe || hs_ev, 1'b1);
    fe_valid = 1'b0;
    ev_valid = 1'b0;
  endtask

  task automatic finish_access(input string tag, input logic src, input logic [L-1:0] leaf);
    int t = 0;
    while (n_done == 0 && t < 200) begin
      cycle();
      t++;
    end
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_n_starts"}, n_st, NP);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_rw%0d", tag, i), st_rw[i], exp_rw(i));
      check($sformatf("%s_bh%0d", tag, i), st_bh[i], exp_bh(i));
      check($sformatf("%s_leaf%0d", tag, i), st_leaf[i], leaf);
    end
    check({tag, "_cur_src"}, cur_src, src);
    check({tag, "_busy_after"}, busy, 1'b0);
    exp_count = (exp_count + 1) % (1 << CW);
    check({tag, "_count"}, access_count, exp_count);
  endtask

  typedef struct {
    logic         fe_v;
    logic [L-1:0] fe_l;
    logic         ev_v;
    logic [L-1:0] ev_l;
    logic         src;
    logic [L-1:0] leaf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 4'hA, 1'b1, 4'h5, 1'b0, 4'hA};
    vecs[1] = '{1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 4'hC};
    vecs[2] = '{1'b1, 4'h7, 1'b1, 4'h1, 1'b0, 4'h7};
    vecs[3] = '{1'b1, 4'h2, 1'b1, 4'hE, 1'b1, 4'hE};
    vecs[4] = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 4'h9};
    vecs[5] = '{1'b1, 4'h6, 1'b0, 4'h0, 1'b0, 4'h6};

    rst      = 1'b1;
    fe_valid = 1'b1;
    fe_leaf  = 4'hF;
    ev_valid = 1'b1;
    ev_leaf  = 4'hF;
    ag_ready = 1'b1;
    wb_go    = 1'b1;
    n_st     = 0;
    n_done   = 0;
    repeat (3) cycle();

    // Reset values, with both requests pending.
    check("rst_fe_ready", fe_ready, 1'b0);
    check("rst_ev_ready", ev_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ag_start", ag_start, 1'b0);
    check("rst_ag_rw", ag_rw, 1'b1);
    check("rst_ag_bh", ag_bh, 1'b0);
    check("rst_ag_leaf", ag_leaf, 4'h0);
    check("rst_cur_src", cur_src, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", access_count, 2'd0);
    fe_valid = 1'b0;
    ev_valid = 1'b0;
    rst      = 1'b0;
    cycle();

    // Reset in RD_WAIT: everything drops at once, nothing is counted.
    fe_valid = 1'b1;
    fe_leaf  = 4'hB;
    wait_grant("rstmid");
    begin
      int t = 0;
      while (n_st < NP - 1 && t < 60) begin
        cycle();
        t++;
      end
    end
    check("rstmid_read_started", n_st, NP - 1);
    check("rstmid_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ag_start", ag_start, 1'b0);
    check("rstmid_done", done, 1'b0);
    check("rstmid_count", access_count, 2'd0);
    cycle();
    check("rstmid_no_done_pulse", n_done, 0);
    ag_cnt   = 0;
    ag_ready = 1'b1;
    rst      = 1'b0;
    cycle();

    // Table: round-robin ties from reset, then single sources; count wraps at 4.
    for (int k = 0; k < 6; k++) begin
      string tag;
      tag      = $sformatf("tbl%0d", k);
      n_st     = 0;
      n_done   = 0;
      fe_valid = vecs[k].fe_v;
      fe_leaf  = vecs[k].fe_l;
      ev_valid = vecs[k].ev_v;
      ev_leaf  = vecs[k].ev_l;
      wait_grant(tag);
      check({tag, "_grant_src"}, hs_ev, vecs[k].src);
      cycle();
      check({tag, "_first_start_latency"}, n_st, 1);
      finish_access(tag, vecs[k].src, vecs[k].leaf);
    end

    // Write-back hold: no write pass until WBGo, and no grant while busy.
    n_st     = 0;
    n_done   = 0;
    wb_go    = 1'b0;
    fe_valid = 1'b1;
    fe_leaf  = 4'h5;
    wait_grant("wb");
    repeat (40) cycle();
    check("wb_reads_only", n_st, NP - 1);
    check("wb_no_done", n_done, 0);
    check("wb_busy", busy, 1'b1);
    ev_valid = 1'b1;
    ev_leaf  = 4'h3;
    cycle();
    check("wb_no_grant_busy", hs_ev, 1'b0);
    ev_valid = 1'b0;
    repeat (19) cycle();
    check("wb_hold_no_start", n_st, NP - 1);
    wb_go = 1'b1;
    cycle();
    check("wb_still_holding", n_st, NP - 1);
    cycle();
    check("wb_write_issued", n_st, NP);
    finish_access("wb", 1'b0, 4'h5);

    // Generator not ready on the first issue: stall, then exactly one pulse.
    n_st     = 0;
    n_done   = 0;
    ag_stall = 1'b1;
    ag_ready = 1'b0;
    fe_valid = 1'b1;
    fe_leaf  = 4'hC;
    wait_grant("stall");
    for (int i = 0; i < 7; i++) begin
      cycle();
      check($sformatf("stall_no_start%0d", i), n_st, 0);
    end
    ag_stall = 1'b0;
    ag_ready = 1'b1;
    cycle();
    check("stall_single_pulse", n_st, 1);
    cycle();
    check("stall_pulse_ended", n_st, 1);
    finish_access("stall", 1'b0, 4'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_access_sched.md
# path_access_sched

Sequences the bucket address generator through a complete ORAM path access and shares it between two requesters: the frontend (real accesses) and the eviction engine (background evictions). Each granted access is run as an optional header pre-read pass, then a full-path read pass, a wait for the stash to release write-back data, and finally a full-path write pass. The block sits between the backend controller's request sources and the address generator's `Start`/`Ready` interface.

## Interface
- `ORAML`, 31: tree depth; leaf label width.
- `CntWidth`, 32: width of the completed-access counter.

- `Clock`  in  1: single clock domain.
- `Reset`  in  1: asynchronous, active-high.
- `FEValid`  in  1: frontend request valid.
- `FELeaf`  in  ORAML: frontend leaf label.
- `FEReady`  out  1: frontend request accepted when `FEValid && FEReady`.
- `EVValid`  in  1: eviction request valid.
- `EVLeaf`  in  ORAML: eviction leaf label.
- `EVReady`  out  1: eviction request accepted when `EVValid && EVReady`.
- `AGStart`  out  1: start pulse to the address generator.
- `AGRW`  out  1: 1 = read pass, 0 = write pass.
- `AGBH`  out  1: 1 = header-only pass, 0 = whole bucket.
- `AGLeaf`  out  ORAML: leaf label of the current access.
- `AGReady`  in  1: address generator idle.
- `WBGo`  in  1: stash has write-back data staged.
- `Busy`  out  1: an access is in flight.
- `CurSrc`  out  1: source of the current access (0 = FE, 1 = EV).
- `Done`  out  1: one-cycle pulse when the write pass completes.
- `AccessCount`  out  CntWidth: number of completed accesses.

## Operation
- States:
  - `IDLE`
  - `HDR_ISSUE`, `HDR_WAIT`
  - `RD_ISSUE`, `RD_WAIT`
  - `WB_HOLD`
  - `WR_ISSUE`, `WR_WAIT`
  - `DONE`
- Arbitration in `IDLE`, round-robin with a `LastGrant` bit:
  - Only one valid: grant it.
  - Both valid: grant the source not equal to `LastGrant`.
  - `FEReady`/`EVReady` are combinational and high only in `IDLE` for the granted source.
  - On handshake: latch the leaf into `AGLeaf`, set `CurSrc`, update `LastGrant`.
- After grant: go to `HDR_ISSUE` if the pre-read is compiled in, else `RD_ISSUE`.
- `*_ISSUE` states:
  - `AGStart = AGReady` (combinational).
  - The state holds until `AGReady = 1`, then moves to the matching `*_WAIT` in the same cycle as the pulse.
- `*_WAIT` states:
  - A `SeenBusy` flag is cleared on entry and set when `AGReady = 0`.
  - Exit when `SeenBusy && AGReady`.
  - `HDR_WAIT` goes to `RD_ISSUE`; `RD_WAIT` goes to `WB_HOLD`; `WR_WAIT` goes to `DONE`.
- `WB_HOLD`: wait for `WBGo = 1`, then go to `WR_ISSUE`. `WBGo` is ignored in all other states.
- `DONE`:
  - `Done = 1` for exactly one cycle.
  - `AccessCount` increments, wrapping modulo 2^CntWidth.
  - Next state is `IDLE`.
- Output encoding:
  - `AGRW = 1` in `HDR_*` and `RD_*`; `AGRW = 0` in `WR_*`.
  - `AGBH = 1` only in `HDR_*`.
  - `AGLeaf` is stable from grant through `DONE`.
- `Busy` is high in every state except `IDLE`.

## Timing
- Reset values:
  - state `IDLE`, `LastGrant = 1` (so FE wins the first tie)
  - `AGStart = 0`, `AGRW = 1`, `AGBH = 0`, `AGLeaf = 0`
  - `Busy = 0`, `CurSrc = 0`, `Done = 0`, `AccessCount = 0`
  - `FEReady = EVReady = 0` only while `Reset` is asserted.
- Handshake at cycle N puts the FSM in `*_ISSUE` at N+1. The earliest `AGStart` is at N+1.
- Reset mid-access: asynchronous return to `IDLE`. No `Done` pulse, no count increment, `AGStart` drops immediately.
- A request whose `Valid` drops before its handshake is never served; no request is taken while `Busy`.
- `AGReady` low on issue: `AGStart` is held low and the FSM stalls in `*_ISSUE`. No pulse is ever issued while `AGReady = 0`.
- If `WBGo` is already high on entry to `WB_HOLD`, `WR_ISSUE` follows on the next cycle.
- Minimum `DONE` to next grant: 1 cycle (`IDLE` lasts at least 1 cycle).

## Configuration
- `PATH_HDR_PREREAD_EN`:
  - Defined: every access begins with a header-only read pass (`AGRW = 1`, `AGBH = 1`) before the full read.
  - Undefined: the `HDR_*` states are not built, and a grant goes directly to `RD_ISSUE`.

## Test plan
- Single FE request, `ORAML = 4`, `FELeaf = 4'hA`, model `AGReady` busy for 5 cycles per pass, `WBGo` high → in order: `AGStart` with (RW=1,BH=1) [macro on], (1,0), (0,0); all with `AGLeaf = 4'hA`; one `Done` pulse; `AccessCount = 1`.
- FE and EV valid together from reset, 4 accesses → grant order FE, EV, FE, EV; `CurSrc` = 0,1,0,1.
- `WBGo` held low 20 cycles after `RD_WAIT` → FSM stays in `WB_HOLD`, no `AGStart`; `WR_ISSUE` is entered 1 cycle after `WBGo` rises.
- `AGReady = 0` on entry to `RD_ISSUE` for 7 cycles → `AGStart = 0` throughout; a single pulse in the first cycle `AGReady = 1`.
- `Reset` asserted in `RD_WAIT` → same cycle: `Busy = 0`, `AGStart = 0`, no `Done`, `AccessCount` unchanged at 0.
- `CntWidth = 2`, 5 accesses → `AccessCount` reads 1, 2, 3, 0, 1.
